// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin, burst-bounded arbiter sharing one big-endian 16-bit memory port between two requesters
module mem_port_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  input  logic [15:0] mem_dout
);
  localparam int CW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [15:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          acc0, acc1, sat;

  // a beat is accepted whenever the granted side is requesting at the edge
  assign acc0 = (state_q == G0) & req0;
  assign acc1 = (state_q == G1) & req1;
  assign sat  = cnt_q == CNT_MAX;

  // next grant: tie from idle goes to the side not served last; burst ends only if the other side waits
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (req0 & req1) ? (last_q ? G0 : G1) : req0 ? G0 : req1 ? G1 : IDLE;
      G0:      state_d = !req0 ? (req1 ? G1 : IDLE) : (sat & req1) ? G1 : G0;
      G1:      state_d = !req1 ? (req0 ? G0 : IDLE) : (sat & req0) ? G0 : G1;
      default: state_d = IDLE;
    endcase
  end

  // burst counter restarts on every new grant and saturates; last tracks the newest owner
  always_comb begin
    cnt_d  = (state_d != state_q && state_d != IDLE) ? '0 :
             ((acc0 | acc1) & !sat) ? cnt_q + 1'b1 : cnt_q;
    last_d = (state_d == G0) ? 1'b0 : (state_d == G1) ? 1'b1 : last_q;
  end

  // read beats capture the combinational memory data and strobe valid for one cycle
  always_comb begin
    rvalid0_d = acc0 & !we0;
    rvalid1_d = acc1 & !we1;
    rdata0_d  = rvalid0_d ? mem_dout : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_dout : rdata1_q;
  end

  // all arbiter state; last resets to R1 so R0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign gnt0     = state_q == G0;
  assign gnt1     = state_q == G1;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign mem_addr = gnt0 ? addr0 : gnt1 ? addr1 : 16'h0000;
  assign mem_din  = gnt0 ? wdata0 : gnt1 ? wdata1 : 16'h0000;
  assign mem_we   = !rst & ((acc0 & we0) | (acc1 & we1));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a behavioural arbiter/memory model for MAX_BURST=4 and MAX_BURST=1
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt0_w, gnt1_w, rv0_w, rv1_w, mwe_w;
  logic [15:0] rd0_w [2];
  logic [15:0] rd1_w [2];
  logic [15:0] maddr_w [2];
  logic [15:0] mdin_w [2];
  logic [15:0] mdout_w [2];
  bit   [7:0]  mem [2][65536];
  bit   [7:0]  ref_mem [2][65536];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          own [2] = '{-1, -1};
  int          run [2] = '{0, 0};
  int          prv [2] = '{1, 1};
  int          mb  [2] = '{4, 1};
  logic        ev  [2][2];
  logic [15:0] erd [2][2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_BURST(4)) u_b4 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .rvalid0(rv0_w[0]), .rvalid1(rv1_w[0]),
    .rdata0(rd0_w[0]), .rdata1(rd1_w[0]), .mem_addr(maddr_w[0]), .mem_din(mdin_w[0]),
    .mem_we(mwe_w[0]), .mem_dout(mdout_w[0])
  );

  mem_port_arbiter #(.MAX_BURST(1)) u_b1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .rvalid0(rv0_w[1]), .rvalid1(rv1_w[1]),
    .rdata0(rd0_w[1]), .rdata1(rd1_w[1]), .mem_addr(maddr_w[1]), .mem_din(mdin_w[1]),
    .mem_we(mwe_w[1]), .mem_dout(mdout_w[1])
  );

  function automatic logic [15:0] nxt(input logic [15:0] a);
    return a + 16'd1;
  endfunction

  assign mdout_w[0] = {mem[0][maddr_w[0]], mem[0][nxt(maddr_w[0])]};
  assign mdout_w[1] = {mem[1][maddr_w[1]], mem[1][nxt(maddr_w[1])]};

  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      if (mwe_w[i]) begin
        mem[i][maddr_w[i]]      = mdin_w[i][15:8];
        mem[i][nxt(maddr_w[i])] = mdin_w[i][7:0];
      end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    own[i] = -1;
    run[i] = 0;
    prv[i] = 1;
    ev[i][0] = 1'b0;
    ev[i][1] = 1'b0;
    erd[i][0] = 16'h0000;
    erd[i][1] = 16'h0000;
  endtask

  task automatic model_step(input int i);
    logic rq [2];
    logic w [2];
    logic [15:0] a [2];
    logic [15:0] d [2];
    int o, nx;
    rq = '{req0, req1};
    w  = '{we0, we1};
    a  = '{addr0, addr1};
    d  = '{wdata0, wdata1};
    o  = own[i];
    ev[i][0] = 1'b0;
    ev[i][1] = 1'b0;
    if (o >= 0 && rq[o]) begin
      if (w[o]) begin
        ref_mem[i][a[o]]      = d[o][15:8];
        ref_mem[i][nxt(a[o])] = d[o][7:0];
      end else begin
        erd[i][o] = {ref_mem[i][a[o]], ref_mem[i][nxt(a[o])]};
        ev[i][o]  = 1'b1;
      end
    end
    if (o < 0)
      nx = (rq[0] && rq[1]) ? 1 - prv[i] : rq[0] ? 0 : rq[1] ? 1 : -1;
    else if (!rq[o])
      nx = rq[1-o] ? 1 - o : -1;
    else
      nx = (run[i] + 1 >= mb[i] && rq[1-o]) ? 1 - o : o;
    if (nx >= 0 && nx != o) begin
      run[i] = 0;
      prv[i] = nx;
    end else if (nx == o && o >= 0) begin
      run[i]++;
    end
    own[i] = nx;
  endtask

  always @(posedge clk or posedge rst)
    for (int i = 0; i < 2; i++)
      if (rst) model_reset(i);
      else model_step(i);

  task automatic cmp(input int i);
    logic rq [2];
    logic w [2];
    logic [15:0] a [2];
    logic [15:0] d [2];
    int o;
    rq = '{req0, req1};
    w  = '{we0, we1};
    a  = '{addr0, addr1};
    d  = '{wdata0, wdata1};
    o  = own[i];
    chk($sformatf("u%0d.gnt0", i), 16'(gnt0_w[i]), 16'(o == 0));
    chk($sformatf("u%0d.gnt1", i), 16'(gnt1_w[i]), 16'(o == 1));
    chk($sformatf("u%0d.rvalid0", i), 16'(rv0_w[i]), 16'(ev[i][0]));
    chk($sformatf("u%0d.rvalid1", i), 16'(rv1_w[i]), 16'(ev[i][1]));
    chk($sformatf("u%0d.rdata0", i), rd0_w[i], erd[i][0]);
    chk($sformatf("u%0d.rdata1", i), rd1_w[i], erd[i][1]);
    chk($sformatf("u%0d.mem_we", i), 16'(mwe_w[i]), 16'(o >= 0 && rq[o] && w[o]));
    chk($sformatf("u%0d.mem_addr", i), maddr_w[i], o >= 0 ? a[o] : 16'h0000);
    chk($sformatf("u%0d.mem_din", i), mdin_w[i], o >= 0 ? d[o] : 16'h0000);
  endtask

  initial forever begin
    @(posedge clk);
    #4;
    cmp(0);
    cmp(1);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tick;
    tick;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_gnt", 16'({gnt1_w[i], gnt0_w[i]}), 16'h0);
      chk("rst_rvalid", 16'({rv1_w[i], rv0_w[i]}), 16'h0);
      chk("rst_rdata0", rd0_w[i], 16'h0000);
      chk("rst_mem_we", 16'(mwe_w[i]), 16'h0);
    end
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hABCD;
    tick;
    chk("wr_gnt0", 16'(gnt0_w[0]), 16'h1);
    chk("wr_mem_we", 16'(mwe_w[0]), 16'h1);
    chk("wr_mem_addr", maddr_w[0], 16'h0010);
    tick;
    we0 = 1'b0;
    tick;
    chk("rd_rvalid0", 16'(rv0_w[0]), 16'h1);
    chk("rd_rdata0", rd0_w[0], 16'hABCD);
    chk("rd_mem_we", 16'(mwe_w[0]), 16'h0);
    addr0 = 16'h0011;
    tick;
    chk("rd_odd_rdata0", rd0_w[0], 16'hCD00);
    req0 = 1'b0;
    tick;
    chk("drop_gnt0", 16'(gnt0_w[0]), 16'h0);
    chk("drop_rvalid0", 16'(rv0_w[0]), 16'h0);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addr0 = 16'h0100 + 16'(2 * i); addr1 = 16'h0200 + 16'(2 * i);
      wdata0 = 16'h1000 + 16'(i);    wdata1 = 16'h2000 + 16'(i);
      tick;
      chk("burst4_gnt0", 16'(gnt0_w[0]), 16'((i / 4) % 2 == 0));
      chk("burst4_gnt1", 16'(gnt1_w[0]), 16'((i / 4) % 2 == 1));
      chk("burst1_gnt0", 16'(gnt0_w[1]), 16'(i % 2 == 0));
    end

    we0 = 1'b0; we1 = 1'b0; addr0 = 16'h0102; addr1 = 16'h0204;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (i >= 1) begin
        chk("alt_gnt", 16'(gnt0_w[1] ^ gnt1_w[1]), 16'h1);
        chk("alt_rvalid0", 16'(rv0_w[1]), 16'(gnt1_w[1]));
        chk("alt_rvalid1", 16'(rv1_w[1]), 16'(gnt0_w[1]));
      end
    end

    req0 = 1'b0; req1 = 1'b0;
    tick;
    tick;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    tick;
    repeat (10) tick;
    chk("late_hold_u0", 16'(gnt0_w[0]), 16'h1);
    chk("late_hold_u1", 16'(gnt0_w[1]), 16'h1);
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0012;
    tick;
    chk("late_switch_u0", 16'(gnt1_w[0]), 16'h1);
    chk("late_lastbeat", 16'(rv0_w[0]), 16'h1);
    chk("late_lastdata", rd0_w[0], 16'hABCD);
    chk("late_switch_u1", 16'(gnt1_w[1]), 16'h1);

    req0 = 1'b0; req1 = 1'b0;
    tick;
    tick;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'hFFFF; wdata0 = 16'h1234;
    tick;
    tick;
    we0 = 1'b0;
    tick;
    chk("wrap_rdata0", rd0_w[0], 16'h1234);
    chk("wrap_byte0000", 16'(mem[0][0]), 16'h0034);
    chk("wrap_byteFFFF", 16'(mem[0][16'hFFFF]), 16'h0012);
    req0 = 1'b0;

    tick;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h3000; wdata1 = 16'h5A5A;
    tick;
    tick;
    addr1 = 16'h3002; wdata1 = 16'h6B6B;
    #1;
    chk("pre_rst_gnt1", 16'(gnt1_w[0]), 16'h1);
    chk("pre_rst_we", 16'(mwe_w[0]), 16'h1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_gnt1", 16'(gnt1_w[i]), 16'h0);
      chk("async_mem_we", 16'(mwe_w[i]), 16'h0);
      chk("async_rvalid1", 16'(rv1_w[i]), 16'h0);
    end
    tick;
    chk("no_partial_wr", {mem[0][16'h3002], mem[0][16'h3003]}, 16'h0000);
    chk("prior_wr_kept", {mem[0][16'h3000], mem[0][16'h3001]}, 16'h5A5A);
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; we1 = 1'b0;
    tick;
    chk("post_rst_r0_u0", 16'(gnt0_w[0]), 16'h1);
    chk("post_rst_r0_u1", 16'(gnt0_w[1]), 16'h1);
    repeat (6) tick;
    req0 = 1'b0; req1 = 1'b0;
    tick;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one port of the 16-bit, byte-addressed, big-endian dual-port memory bank. Typical use: CPU data access (R0) and the boot/DMA loader (R1) on port A. It grants the port with round-robin priority and a bounded burst length, drives address, data and write-enable to the memory, and returns registered read data with a one-cycle valid strobe. The memory writes on the falling edge of the granted cycle and reads combinationally.

## Interface
- MAX_BURST, 4, max accepted beats per grant while the other requester waits; ≥1
- clk  in  1  system clock, rising-edge logic
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request, held until accepted
- we0 / we1  in  1  1 = write, 0 = read; sampled with req
- addr0 / addr1  in  16  byte address of the high byte; addr+1 holds the low byte
- wdata0 / wdata1  in  16  write data, [15:8] to addr, [7:0] to addr+1
- gnt0 / gnt1  out  1  registered grant (one-hot or both 0)
- rvalid0 / rvalid1  out  1  one-cycle strobe: rdata valid
- rdata0 / rdata1  out  16  registered read data
- mem_addr  out  16  to memory address port
- mem_din  out  16  to memory data-in
- mem_we  out  1  to memory write-enable
- mem_dout  in  16  from memory data-out (combinational read)

## Operation
- States: IDLE, G0, G1. gnt0 = (state==G0), gnt1 = (state==G1).
- Beat accepted on a rising edge when reqN & gntN. Only the granted side's signals reach the memory.
- Memory drive (combinational from state):
  - G0 passes addr0/wdata0 and sets mem_we = we0 & req0; G1 likewise for R1.
  - IDLE drives mem_addr = 0, mem_din = 0, mem_we = 0.
- Read beat: rdataN <= mem_dout at the accepting edge; rvalidN = 1 for the next cycle only. rdataN holds otherwise.
- Write beat: the memory commits at the falling edge inside the granted cycle. No rvalid.
- last register: records the most recently granted requester. Reset value 1, so R0 wins the first tie.
- cnt: counts accepted beats, width max(1, clog2(MAX_BURST)). Cleared on entry to G0/G1. Increments per accepted beat and saturates at MAX_BURST-1.
- Transitions, evaluated at each rising edge:
  - IDLE: both requesting → grant the requester other than last. One requesting → grant it. None → stay IDLE.
  - G0: !req0 → G1 if req1, else IDLE.
  - G0: beat accepted with cnt==MAX_BURST-1 and req1 → G1.
  - G0: otherwise stay in G0.
  - G1 mirrors G0.
  - A switch goes directly from G0 to G1 (or back) with no idle cycle, and updates last.
- Address arithmetic is done by the memory. Address 0xFFFF pairs with 0x0000 (wraps); odd addresses are legal. The arbiter does no alignment check.

## Timing
- Reset (async, immediate): state=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, cnt=0, last=1, mem_we=0, mem_addr=0, mem_din=0.
- No memory write can occur while rst is high.
- Grant latency from IDLE: req sampled high at edge k → gnt high after edge k. The first beat is accepted at edge k+1.
- Sustained throughput: 1 beat/cycle per granted requester.
- Read latency: data valid in the cycle after the accepting edge.
- Requester drops req while granted: gnt stays high that cycle, mem_we=0 (gated by req), no beat. Grant moves or releases at the next edge.
- Idle contender, owner keeps requesting: grant is held indefinitely; cnt stays saturated.
- Late contender: if the other side raises req after cnt saturates, the switch happens after the owner's next accepted beat.
- MAX_BURST=1 with both requesting continuously: strict alternation, one beat each.
- Reset mid-burst: pending beat discarded, rvalid cleared, no partial write. After release, arbitration restarts from IDLE with R0 priority.
- Changing reqN/weN/addrN/wdataN while granted is allowed. Each edge samples the current values.

## Test plan
- Reset then req0 write addr=0x0010 wdata=0xABCD. Then req0 read 0x0010 → mem_we only in the granted write cycle; rdata0=0xABCD with rvalid0 one cycle after the read edge. Read of 0x0011 returns 0xCDxx.
- Both requesters write continuously, MAX_BURST=4 → gnt pattern 4 cycles G0, 4 cycles G1, repeating, with no idle gap. First grant goes to R0.
- MAX_BURST=1, both requesters read continuously → gnt0/gnt1 alternate every cycle. Each rvalid pulses on alternate cycles with the correct data.
- R0 alone for 10 beats, then req1 rises → R0 keeps the grant for exactly one more beat, then G1.
- Write 0x1234 at addr=0xFFFF, then read 0xFFFF → 0x1234 returned. Memory byte 0x0000 = 0x34.
- Assert rst asynchronously mid-G1 write burst → gnt1, rvalid1 and mem_we drop immediately, without waiting for a clock edge. After release, both requesting → R0 granted first.
